// File: rtl/poly_voice_mixer.sv
// rtl/poly_voice_mixer.sv - multi-voice stereo wavetable mixer with per-frame saturation
// Optional: define PAN_EN for per-voice pan scaling (adds one pipeline stage).
module poly_voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 18,
    parameter int ADDR_W     = 10,
    parameter int ENV_W      = 17,
    parameter int GUARD_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                voice_valid,
    output logic                voice_ready,
    input  logic [ADDR_W-1:0]   wavetable_r,
    input  logic [ADDR_W-1:0]   wavetable_l,
    input  logic [ENV_W-1:0]    volume_adsr,
    input  logic [ENV_W-1:0]    velocity,
    input  logic [7:0]          pan,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    input  logic                tick48k,
    output logic [SAMPLE_W-1:0] sound_r,
    output logic [SAMPLE_W-1:0] sound_l,
    output logic [1:0]          clip,
    output logic                dropped
);
    localparam int ACC_W = SAMPLE_W + GUARD_W;
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int MUL_W = SAMPLE_W + ENV_W;
`ifdef PAN_EN
    localparam int STAGES = 5;
`else
    localparam int STAGES = 4;
`endif
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [SAMPLE_W-1:0]     MIDPOINT = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                       run_q;
    logic [CNT_W-1:0]           voice_cnt;
    logic [STAGES-1:0]          stage_v;   // stage_v[k] is high in the cycle after edge T+k+1
    logic [ADDR_W-1:0]          addr_l_q;
    logic [ENV_W-1:0]           vol_q, vel_q;
    logic [ENV_W-1:0]           gain_raw, env_unused;
    logic [ENV_W-2:0]           gain_q;
    logic signed [SAMPLE_W-1:0] s_val;
    logic signed [MUL_W-1:0]    mul_full;
    logic signed [ACC_W-1:0]    prod_q, acc_r, acc_l, contrib;
    logic [SAMPLE_W-1:0]        sat_r, sat_l;
    logic                       clip_r, clip_l, accept, add_r, add_l;

    assign voice_ready = run_q && !stage_v[0] && (voice_cnt < CNT_W'(NUM_VOICES));
    assign accept      = voice_valid && voice_ready;

    // Gain is the upper half of the envelope product, clamped to ENV_W-1 bits (just under unity).
    assign {gain_raw, env_unused} = vol_q * vel_q;
    assign s_val    = {~rom_data[SAMPLE_W-1], rom_data[SAMPLE_W-2:0]};
    assign mul_full = s_val * $signed({1'b0, gain_q});

`ifdef PAN_EN
    logic [7:0]              pan_q, pan_g, pan_l;
    logic [8:0]              pan_fac;
    logic signed [ACC_W+9:0] pan_full;
    logic signed [ACC_W-1:0] scaled_q;

    // Right product sits in prod_q while stage_v[2] is high, left product the cycle after.
    assign pan_fac  = stage_v[2] ? ({1'b0, pan_g} + 9'd1) : (9'd256 - {1'b0, pan_l});
    assign pan_full = prod_q * $signed({1'b0, pan_fac});
    assign contrib  = scaled_q;
    assign add_r    = stage_v[3];
    assign add_l    = stage_v[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_q    <= '0;
            pan_g    <= '0;
            pan_l    <= '0;
            scaled_q <= '0;
        end else begin
            if (accept)
                pan_q <= pan;
            pan_g <= pan_q;
            if (stage_v[2])
                pan_l <= pan_g;
            scaled_q <= ACC_W'(pan_full >>> 8);
        end
    end
`else
    logic [7:0] pan_unused;

    assign pan_unused = pan;
    assign contrib    = prod_q;
    assign add_r      = stage_v[2];
    assign add_l      = stage_v[3];
`endif

    always_comb begin
        sat_r  = acc_r[SAMPLE_W-1:0];
        sat_l  = acc_l[SAMPLE_W-1:0];
        clip_r = 1'b0;
        clip_l = 1'b0;
        if (acc_r > SAT_MAX) begin
            sat_r  = SAT_MAX[SAMPLE_W-1:0];
            clip_r = 1'b1;
        end else if (acc_r < SAT_MIN) begin
            sat_r  = SAT_MIN[SAMPLE_W-1:0];
            clip_r = 1'b1;
        end
        if (acc_l > SAT_MAX) begin
            sat_l  = SAT_MAX[SAMPLE_W-1:0];
            clip_l = 1'b1;
        end else if (acc_l < SAT_MIN) begin
            sat_l  = SAT_MIN[SAMPLE_W-1:0];
            clip_l = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            stage_v   <= '0;
            voice_cnt <= '0;
            rom_addr  <= '0;
            addr_l_q  <= '0;
            vol_q     <= '0;
            vel_q     <= '0;
            gain_q    <= '0;
            prod_q    <= '0;
            acc_r     <= '0;
            acc_l     <= '0;
            sound_r   <= MIDPOINT;
            sound_l   <= MIDPOINT;
            clip      <= 2'b00;
            dropped   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            stage_v <= {stage_v[STAGES-2:0], accept};
            gain_q  <= gain_raw[ENV_W-1] ? '1 : gain_raw[ENV_W-2:0];
            prod_q  <= ACC_W'(mul_full >>> (ENV_W - 1));
            if (accept) begin
                rom_addr <= wavetable_r;
                addr_l_q <= wavetable_l;
                vol_q    <= volume_adsr;
                vel_q    <= velocity;
            end else if (stage_v[0]) begin
                rom_addr <= addr_l_q;
            end
            dropped <= tick48k && voice_valid && (voice_cnt >= CNT_W'(NUM_VOICES));
            if (tick48k) begin
                // Contributions landing on the tick edge open the new frame.
                sound_r   <= {~sat_r[SAMPLE_W-1], sat_r[SAMPLE_W-2:0]};
                sound_l   <= {~sat_l[SAMPLE_W-1], sat_l[SAMPLE_W-2:0]};
                clip      <= {clip_r, clip_l};
                acc_r     <= add_r ? contrib : '0;
                acc_l     <= add_l ? contrib : '0;
                voice_cnt <= accept ? CNT_W'(1) : '0;
            end else begin
                if (add_r)
                    acc_r <= acc_r + contrib;
                if (add_l)
                    acc_l <= acc_l + contrib;
                if (accept)
                    voice_cnt <= voice_cnt + CNT_W'(1);
            end
        end
    end
endmodule
